dcache_write_buffer: RTL
========================

# dcache_write_buffer

Posted write buffer between the data cache's memory port and the slow data memory. Dirty-line writebacks from the cache are acknowledged as soon as they are buffered, then drained to memory in the background. Read misses bypass queued writes, or are served directly from the buffer on an address match. The cache-side port mirrors the slow-memory protocol exactly, so the block drops in between `D_cache` and the `mem_*_D` pins of `CHIP`.

## Interface

Parameters:
- `DEPTH`, 4: number of line entries; power of two, ≥2.
- `LINE_W`, 128: line width in bits.
- `TAG_W`, 28: line address width (bits 31:4).

Ports:
- Clock and reset:
  - `clk`  in  1  single clock, all state on rising edge.
  - `proc_reset`  in  1  asynchronous, active-high reset.
- Cache side:
  - `c_read`  in  1  cache line read request; held until `c_ready`.
  - `c_write`  in  1  cache line write request; held until `c_ready`.
  - `c_addr`  in  TAG_W  line address.
  - `c_wdata`  in  LINE_W  write line.
  - `c_rdata`  out  LINE_W  read line, valid while `c_ready`=1.
  - `c_ready`  out  1  one-cycle acknowledge.
- Memory side:
  - `mem_read`  out  1  memory read request.
  - `mem_write`  out  1  memory write request.
  - `mem_addr`  out  TAG_W  memory line address.
  - `mem_wdata`  out  LINE_W  memory write line.
  - `mem_rdata`  in  LINE_W  memory read line.
  - `mem_ready`  in  1  one-cycle memory acknowledge.
- Status:
  - `buf_empty`  out  1  no entries held; the testbench waits on this before final memory compare.

## Operation

- Storage: FIFO of `DEPTH` entries {valid, tag, data}, head/tail pointers, count 0..DEPTH. `full` = count==DEPTH.
- FSM states: IDLE, MEM_RD, MEM_WR, RESP.
- Requests are evaluated only in IDLE, in this priority order:
  1. `c_read` and tag matches a valid entry: latch that entry's data into `c_rdata`; go to RESP. No memory access.
  2. `c_read` with no match: latch `c_addr`; go to MEM_RD.
  3. `c_write` and tag matches a valid entry: overwrite that entry's data in place (coalesce, count unchanged); go to RESP.
  4. `c_write`, no match, not full: push at tail; go to RESP.
  5. Not empty (this includes full with a write pending): go to MEM_WR with the head entry.
  6. Otherwise stay in IDLE.
- MEM_RD: `mem_read`=1 with the latched address until `mem_ready`. On `mem_ready`, capture `mem_rdata` into `c_rdata`; go to RESP.
- MEM_WR: `mem_write`=1 with head tag/data until `mem_ready`. On `mem_ready`, pop head (count−1); go to IDLE.
- RESP: `c_ready`=1 for exactly one cycle; go to IDLE.
- Tags are unique in the buffer because of coalescing, so at most one entry matches. A read bypassing writes is safe because a non-matching read cannot alias a buffered line.
- `c_read` and `c_write` both high: the read is served, the write is ignored until it is presented again after `c_ready`.
- The request sampled in the cycle after `c_ready` is treated as a new request.

## Timing

- Reset (async, immediate) sets all outputs to 0: `c_ready`, `mem_read`, `mem_write`, `mem_addr`, `mem_wdata`, `c_rdata`. Count and pointers clear to 0, FSM goes to IDLE, `buf_empty`=1. A memory transaction in flight is abandoned and its data is lost.
- Write accept: request seen in IDLE at cycle N gives `c_ready` at N+1.
- Read hit: `c_ready` with data at N+1.
- Read miss: `mem_read` from N+1 until `mem_ready` at cycle M; `c_ready` at M+1.
- Drain: `mem_write` from N+1 until `mem_ready` at M; pop at the M edge. Consecutive drains have at least one idle cycle between them.
- Full with a write pending: the cache stalls for one full drain plus 2 cycles.
- Head-pointer wrap uses modulo `DEPTH`.
- `buf_empty` is combinational from count. It is 1 only when count==0 and the FSM is not in MEM_WR.

## Structure

- Package `dcache_wb_pkg`: state enum {IDLE, MEM_RD, MEM_WR, RESP}, `LINE_W`/`TAG_W` defaults, entry struct {valid, tag, data}.
- Sub-module `wb_fifo_cam`: entry array, head/tail/count, push, pop, in-place overwrite by index, one-hot match vector, `full`/`empty`.
- The top level holds the FSM and the output registers.

## Test plan

- Single write to 0x100 with `mem_ready` delay of 5 cycles: `c_ready` at N+1; `mem_write` for 0x100 follows; after the pop, `buf_empty`=1 and memory holds the data.
- Four writes to 0x10..0x13 with memory stalled, then a fifth to 0x14: the first four ack in 2 cycles each. The fifth acks only after the 0x10 drain completes. Memory write order is 0x10, 0x11, 0x12, 0x13, 0x14.
- Write 0x20=A, write 0x20=B, then read 0x20: count stays 1; the read returns B at N+1 with no `mem_read`; a single memory write of B follows.
- Buffer holds 0x30, then read 0x40: `mem_read`(0x40) is issued before `mem_write`(0x30); `c_rdata` equals the memory data.
- Assert `proc_reset` during MEM_WR: `mem_write` drops in the same cycle; after release, `buf_empty`=1 and no `c_ready` is produced.
- `c_read` and `c_write` both high to an unbuffered address: the read is served; the buffer count is unchanged after `c_ready`.

Source files
------------

// File: rtl/dcache_wb_pkg.sv
// Shared types for the data-cache posted write buffer: FSM states, default
// widths and the buffer entry layout.
package dcache_wb_pkg;

  localparam int LINE_W_DEF = 128;
  localparam int TAG_W_DEF  = 28;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MEM_RD = 2'd1,
    MEM_WR = 2'd2,
    RESP   = 2'd3
  } wb_state_e;

  typedef struct packed {
    logic                  valid;
    logic [TAG_W_DEF-1:0]  tag;
    logic [LINE_W_DEF-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wb_fifo_cam.sv
// Line-entry FIFO with a tag CAM: push at tail, pop at head, in-place data
// overwrite by index, and a single-hit lookup against the cache address.
module wb_fifo_cam
  import dcache_wb_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int TAG_W  = TAG_W_DEF,
  parameter int LINE_W = LINE_W_DEF,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              push_i,
  input  logic [TAG_W-1:0]  push_tag_i,
  input  logic [LINE_W-1:0] push_data_i,
  input  logic              pop_i,
  input  logic              ovr_i,
  input  logic [IDX_W-1:0]  ovr_idx_i,
  input  logic [LINE_W-1:0] ovr_data_i,
  input  logic [TAG_W-1:0]  lookup_tag_i,
  output logic              hit_o,
  output logic [IDX_W-1:0]  hit_idx_o,
  output logic [LINE_W-1:0] hit_data_o,
  output logic [TAG_W-1:0]  head_tag_o,
  output logic [LINE_W-1:0] head_data_o,
  output logic              full_o,
  output logic              empty_o
);

  typedef struct packed {
    logic              valid;
    logic [TAG_W-1:0]  tag;
    logic [LINE_W-1:0] data;
  } entry_t;

  localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);
  localparam logic [IDX_W:0]   CNT_ONE = (IDX_W+1)'(1);
  localparam logic [IDX_W:0]   CNT_MAX = (IDX_W+1)'(DEPTH);

  entry_t            ent_q [DEPTH];
  logic [IDX_W-1:0]  head_q;
  logic [IDX_W-1:0]  tail_q;
  logic [IDX_W:0]    count_q;
  logic [DEPTH-1:0]  match_s;
  logic              push_ok_s;
  logic              pop_ok_s;

  assign full_o    = (count_q == CNT_MAX);
  assign empty_o   = (count_q == '0);
  assign push_ok_s = push_i && !full_o;
  assign pop_ok_s  = pop_i && !empty_o;

  assign head_tag_o  = ent_q[head_q].tag;
  assign head_data_o = ent_q[head_q].data;

  // Coalescing keeps tags unique, so at most one match bit is ever set and
  // OR-reducing the index/data is an exact select.
  always_comb begin
    match_s    = '0;
    hit_idx_o  = '0;
    hit_data_o = '0;
    for (int i = 0; i < DEPTH; i++) begin
      match_s[i] = ent_q[i].valid && (ent_q[i].tag == lookup_tag_i);
      hit_idx_o  = hit_idx_o | ({IDX_W{match_s[i]}} & IDX_W'(i));
      hit_data_o = hit_data_o | ({LINE_W{match_s[i]}} & ent_q[i].data);
    end
  end

  assign hit_o = |match_s;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ent_q[i] <= '0;
      end
    end else begin
      if (push_ok_s) begin
        ent_q[tail_q] <= '{valid: 1'b1, tag: push_tag_i, data: push_data_i};
        tail_q        <= tail_q + IDX_ONE;
      end
      if (ovr_i) begin
        ent_q[ovr_idx_i].data <= ovr_data_i;
      end
      if (pop_ok_s) begin
        ent_q[head_q].valid <= 1'b0;
        head_q              <= head_q + IDX_ONE;
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_q <= count_q + CNT_ONE;
        2'b01:   count_q <= count_q - CNT_ONE;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/dcache_write_buffer.sv
// Posted write buffer between the data cache and slow memory: writes are
// acknowledged once buffered and drained in the background; reads bypass.
module dcache_write_buffer
  import dcache_wb_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int LINE_W = LINE_W_DEF,
  parameter int TAG_W  = TAG_W_DEF
) (
  input  logic              clk,
  input  logic              proc_reset,
  input  logic              c_read,
  input  logic              c_write,
  input  logic [TAG_W-1:0]  c_addr,
  input  logic [LINE_W-1:0] c_wdata,
  output logic [LINE_W-1:0] c_rdata,
  output logic              c_ready,
  output logic              mem_read,
  output logic              mem_write,
  output logic [TAG_W-1:0]  mem_addr,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              buf_empty
);

  localparam int IDX_W = $clog2(DEPTH);

  wb_state_e         state_q, state_d;
  logic              c_ready_q, c_ready_d;
  logic [LINE_W-1:0] c_rdata_q, c_rdata_d;
  logic              mem_read_q, mem_read_d;
  logic              mem_write_q, mem_write_d;
  logic [TAG_W-1:0]  mem_addr_q, mem_addr_d;
  logic [LINE_W-1:0] mem_wdata_q, mem_wdata_d;

  logic              push_s, pop_s, ovr_s;
  logic              hit_s, full_s, empty_s;
  logic [IDX_W-1:0]  hit_idx_s;
  logic [LINE_W-1:0] hit_data_s, head_data_s;
  logic [TAG_W-1:0]  head_tag_s;

  wb_fifo_cam #(
    .DEPTH  (DEPTH),
    .TAG_W  (TAG_W),
    .LINE_W (LINE_W)
  ) u_fifo (
    .clk_i        (clk),
    .rst_i        (proc_reset),
    .push_i       (push_s),
    .push_tag_i   (c_addr),
    .push_data_i  (c_wdata),
    .pop_i        (pop_s),
    .ovr_i        (ovr_s),
    .ovr_idx_i    (hit_idx_s),
    .ovr_data_i   (c_wdata),
    .lookup_tag_i (c_addr),
    .hit_o        (hit_s),
    .hit_idx_o    (hit_idx_s),
    .hit_data_o   (hit_data_s),
    .head_tag_o   (head_tag_s),
    .head_data_o  (head_data_s),
    .full_o       (full_s),
    .empty_o      (empty_s)
  );

  // Requests are only arbitrated in IDLE; read beats write beats drain, except
  // that a write to a full buffer with no coalescing target forces a drain.
  always_comb begin
    state_d     = state_q;
    c_ready_d   = 1'b0;
    c_rdata_d   = c_rdata_q;
    mem_read_d  = mem_read_q;
    mem_write_d = mem_write_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    push_s      = 1'b0;
    pop_s       = 1'b0;
    ovr_s       = 1'b0;
    case (state_q)
      IDLE: begin
        if (c_read && hit_s) begin
          c_rdata_d = hit_data_s;
          c_ready_d = 1'b1;
          state_d   = RESP;
        end else if (c_read) begin
          mem_read_d = 1'b1;
          mem_addr_d = c_addr;
          state_d    = MEM_RD;
        end else if (c_write && hit_s) begin
          ovr_s     = 1'b1;
          c_ready_d = 1'b1;
          state_d   = RESP;
        end else if (c_write && !full_s) begin
          push_s    = 1'b1;
          c_ready_d = 1'b1;
          state_d   = RESP;
        end else if (!empty_s) begin
          mem_write_d = 1'b1;
          mem_addr_d  = head_tag_s;
          mem_wdata_d = head_data_s;
          state_d     = MEM_WR;
        end else begin
          state_d = IDLE;
        end
      end
      MEM_RD: begin
        if (mem_ready) begin
          mem_read_d = 1'b0;
          c_rdata_d  = mem_rdata;
          c_ready_d  = 1'b1;
          state_d    = RESP;
        end else begin
          state_d = MEM_RD;
        end
      end
      MEM_WR: begin
        if (mem_ready) begin
          mem_write_d = 1'b0;
          pop_s       = 1'b1;
          state_d     = IDLE;
        end else begin
          state_d = MEM_WR;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        mem_read_d  = 1'b0;
        mem_write_d = 1'b0;
        state_d     = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge proc_reset) begin
    if (proc_reset) begin
      state_q     <= IDLE;
      c_ready_q   <= 1'b0;
      c_rdata_q   <= '0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      c_ready_q   <= c_ready_d;
      c_rdata_q   <= c_rdata_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign c_ready   = c_ready_q;
  assign c_rdata   = c_rdata_q;
  assign mem_read  = mem_read_q;
  assign mem_write = mem_write_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  // The head entry stays counted until its drain completes.
  assign buf_empty = empty_s && (state_q != MEM_WR);

endmodule
